hdr_ddr_target_rx: RTL and testbench

HDR_DDR_TARGET_RX -- requirements
Module: hdr_ddr_target_rx

---
 rtl/hdr_ddr_target_rx.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_hdr_ddr_target_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_ddr_target_rx.sv
// +--------------------------------------------------------------------------+
// | hdr_ddr_target_rx : HDR-DDR target receive word decoder and pattern det  |
// | Revision 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module hdr_ddr_target_rx (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_hdr_en,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_word_valid,
  output logic [1:0]  o_word_type,
  output logic [15:0] o_payload,
  output logic        o_rnw,
  output logic [6:0]  o_cmd_code,
  output logic [6:0]  o_target_addr,
  output logic        o_parity_err,
  output logic        o_preamble_err,
  output logic        o_crc_err,
  output logic        o_restart_det,
  output logic        o_exit_det,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PREAMBLE     = 3'd1,
    S_PAYLOAD      = 3'd2,
    S_PARITY       = 3'd3,
    S_CRC          = 3'd4,
    S_WAIT_PATTERN = 3'd5
  } state_t;

  localparam logic [1:0] TYPE_CMD  = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CRC  = 2'b10;
  localparam logic [4:0] CRC_SEED  = 5'h1F;
  localparam logic [3:0] CRC_TOKEN = 4'hC;

  state_t      state_q, state_d;
  logic        scl_q, sda_q;
  logic [2:0]  pat_cnt_q, pat_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        pre_q, pre_d;
  logic [15:0] shift_q, shift_d;
  logic        pa1_q, pa1_d;
  logic        is_data_q, is_data_d;
  logic        cmd_exp_q, cmd_exp_d;
  logic [4:0]  crc_q, crc_d;
  logic        valid_q, valid_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] payload_q, payload_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  code_q, code_d;
  logic [6:0]  addr_q, addr_d;
  logic        perr_q, perr_d;
  logic        pre_err_q, pre_err_d;
  logic        crc_err_q, crc_err_d;
  logic        restart_q, restart_d;
  logic        exit_q, exit_d;

  logic scl_edge, scl_rise, sda_fall, fall_counted;
  logic exp_pa1, exp_pa0, word_perr;

  assign scl_edge     = i_scl ^ scl_q;
  assign scl_rise     = scl_edge & i_scl;
  assign sda_fall     = sda_q & ~i_sda;
  assign fall_counted = ~scl_edge & ~i_scl & sda_fall;
  assign exp_pa1      = ^(shift_q & 16'hAAAA);
  assign exp_pa0      = ~^(shift_q & 16'h5555);

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = c[4] ^ b;
    return {c[3], c[2], c[1] ^ fb, c[0], fb};
  endfunction

  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pre_d     = pre_q;
    shift_d   = shift_q;
    pa1_d     = pa1_q;
    is_data_d = is_data_q;
    cmd_exp_d = cmd_exp_q;
    crc_d     = crc_q;
    type_d    = type_q;
    payload_d = payload_q;
    rnw_d     = rnw_q;
    code_d    = code_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    pre_err_d = 1'b0;
    crc_err_d = 1'b0;
    restart_d = 1'b0;
    exit_d    = 1'b0;
    word_perr = (pa1_q != exp_pa1) || (i_sda != exp_pa0);

    if (!i_hdr_en) begin
      state_d   = S_IDLE;
      pat_cnt_d = 3'd0;
      bit_cnt_d = 4'd0;
    end else if (state_q == S_IDLE) begin
      state_d   = S_PREAMBLE;
      cmd_exp_d = 1'b1;
      pat_cnt_d = 3'd0;
      bit_cnt_d = 4'd0;
    end else begin
      if (scl_edge) begin
        pat_cnt_d = 3'd0;
      end else if (fall_counted) begin
        pat_cnt_d = pat_cnt_q + 3'd1;
      end

      // Bus patterns override whatever the current edge would have captured
      if (fall_counted && (pat_cnt_q == 3'd3)) begin
        exit_d    = 1'b1;
        state_d   = S_IDLE;
        pat_cnt_d = 3'd0;
        bit_cnt_d = 4'd0;
      end else if (scl_rise && i_sda && (pat_cnt_q >= 3'd2)) begin
        restart_d = 1'b1;
        state_d   = S_PREAMBLE;
        cmd_exp_d = 1'b1;
        bit_cnt_d = 4'd0;
      end else if (scl_edge) begin
        case (state_q)
          S_PREAMBLE: begin
            if (bit_cnt_q == 4'd0) begin
              pre_d     = i_sda;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              if (cmd_exp_q) begin
                if ({pre_q, i_sda} == 2'b01) begin
                  state_d   = S_PAYLOAD;
                  is_data_d = 1'b0;
                end else begin
                  pre_err_d = 1'b1;
                  state_d   = S_WAIT_PATTERN;
                end
              end else begin
                case ({pre_q, i_sda})
                  2'b10: begin
                    state_d   = S_PAYLOAD;
                    is_data_d = 1'b1;
                  end
                  2'b01: state_d = S_CRC;
                  default: begin
                    pre_err_d = 1'b1;
                    state_d   = S_WAIT_PATTERN;
                  end
                endcase
              end
            end
          end
          S_PAYLOAD: begin
            shift_d   = {shift_q[14:0], i_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (is_data_q) begin
              crc_d = crc5_step(crc_q, i_sda);
            end
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = 4'd0;
              state_d   = S_PARITY;
            end
          end
          S_PARITY: begin
            if (bit_cnt_q == 4'd0) begin
              pa1_d     = i_sda;
              bit_cnt_d = 4'd1;
            end else begin
              bit_cnt_d = 4'd0;
              valid_d   = 1'b1;
              type_d    = is_data_q ? TYPE_DATA : TYPE_CMD;
              payload_d = shift_q;
              perr_d    = word_perr;
              if (!is_data_q) begin
                rnw_d     = shift_q[15];
                code_d    = shift_q[14:8];
                addr_d    = shift_q[7:1];
                crc_d     = CRC_SEED;
                cmd_exp_d = 1'b0;
              end
              // A read hands SDA to the target transmitter
              if (word_perr || (!is_data_q && shift_q[15])) begin
                state_d = S_WAIT_PATTERN;
              end else begin
                state_d = S_PREAMBLE;
              end
            end
          end
          S_CRC: begin
            shift_d   = {shift_q[14:0], i_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              valid_d   = 1'b1;
              type_d    = TYPE_CRC;
              payload_d = {7'd0, shift_q[7:0], i_sda};
              crc_err_d = (shift_q[7:4] != CRC_TOKEN) || ({shift_q[3:0], i_sda} != crc_q);
              state_d   = S_WAIT_PATTERN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= S_IDLE;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      pat_cnt_q <= 3'd0;
      bit_cnt_q <= 4'd0;
      pre_q     <= 1'b0;
      shift_q   <= 16'd0;
      pa1_q     <= 1'b0;
      is_data_q <= 1'b0;
      cmd_exp_q <= 1'b0;
      crc_q     <= CRC_SEED;
      valid_q   <= 1'b0;
      type_q    <= 2'b00;
      payload_q <= 16'd0;
      rnw_q     <= 1'b0;
      code_q    <= 7'd0;
      addr_q    <= 7'd0;
      perr_q    <= 1'b0;
      pre_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      restart_q <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_q     <= i_scl;
      sda_q     <= i_sda;
      pat_cnt_q <= pat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pre_q     <= pre_d;
      shift_q   <= shift_d;
      pa1_q     <= pa1_d;
      is_data_q <= is_data_d;
      cmd_exp_q <= cmd_exp_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
      type_q    <= type_d;
      payload_q <= payload_d;
      rnw_q     <= rnw_d;
      code_q    <= code_d;
      addr_q    <= addr_d;
      perr_q    <= perr_d;
      pre_err_q <= pre_err_d;
      crc_err_q <= crc_err_d;
      restart_q <= restart_d;
      exit_q    <= exit_d;
    end
  end

  assign o_word_valid   = valid_q;
  assign o_word_type    = type_q;
  assign o_payload      = payload_q;
  assign o_rnw          = rnw_q;
  assign o_cmd_code     = code_q;
  assign o_target_addr  = addr_q;
  assign o_parity_err   = perr_q;
  assign o_preamble_err = pre_err_q;
  assign o_crc_err      = crc_err_q;
  assign o_restart_det  = restart_q;
  assign o_exit_det     = exit_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hdr_ddr_target_rx.sv
// +--------------------------------------------------------------------------+
// | tb_hdr_ddr_target_rx : randomized bench with transaction-level model     |
// | Revision 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hdr_ddr_target_rx;

  localparam int K_WORD    = 0;
  localparam int K_PREERR  = 1;
  localparam int K_RESTART = 2;
  localparam int K_EXIT    = 3;
  localparam int M_CMD     = 0;
  localparam int M_DATA    = 1;
  localparam int M_WAIT    = 2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  wtype;
    logic [15:0] payload;
    logic        perr;
    logic        cerr;
    logic        is_cmd;
    logic        rnw;
    logic [6:0]  code;
    logic [6:0]  addr;
  } ev_t;

  logic        clk, rst_n, hdr_en, scl, sda;
  logic        word_valid, rnw, parity_err, preamble_err, crc_err, restart_det, exit_det, busy;
  logic [1:0]  word_type;
  logic [15:0] payload;
  logic [6:0]  cmd_code, target_addr;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_mode = M_CMD;
  logic [4:0] m_crc = 5'h1F;
  ev_t  exp_q[$];
  ev_t  mon_ev;

  hdr_ddr_target_rx dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_hdr_en       (hdr_en),
    .i_scl          (scl),
    .i_sda          (sda),
    .o_word_valid   (word_valid),
    .o_word_type    (word_type),
    .o_payload      (payload),
    .o_rnw          (rnw),
    .o_cmd_code     (cmd_code),
    .o_target_addr  (target_addr),
    .o_parity_err   (parity_err),
    .o_preamble_err (preamble_err),
    .o_crc_err      (crc_err),
    .o_restart_det  (restart_det),
    .o_exit_det     (exit_det),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] par_bits(input logic [15:0] w);
    logic p1, p0;
    p1 = 1'b0;
    p0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) p1 = p1 ^ w[i];
      else            p0 = p0 ^ w[i];
    end
    return {p1, p0};
  endfunction

  function automatic logic [4:0] crc5_word(input logic [4:0] seed, input logic [15:0] w);
    logic [4:0] r;
    logic       fb;
    r = seed;
    for (int i = 15; i >= 0; i--) begin
      fb = r[4] ^ w[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  // Any output pulse consumes the oldest expected event
  always @(negedge clk) begin
    if (word_valid | preamble_err | crc_err | parity_err | restart_det | exit_det) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk_eq("valid",      {31'd0, word_valid},   {31'd0, mon_ev.kind == K_WORD});
        chk_eq("pre_err",    {31'd0, preamble_err}, {31'd0, mon_ev.kind == K_PREERR});
        chk_eq("restart",    {31'd0, restart_det},  {31'd0, mon_ev.kind == K_RESTART});
        chk_eq("exit",       {31'd0, exit_det},     {31'd0, mon_ev.kind == K_EXIT});
        chk_eq("crc_err",    {31'd0, crc_err},      {31'd0, mon_ev.cerr});
        chk_eq("parity_err", {31'd0, parity_err},   {31'd0, mon_ev.perr});
        if (mon_ev.kind == K_WORD) begin
          chk_eq("word_type", {30'd0, word_type}, {30'd0, mon_ev.wtype});
          chk_eq("payload",   {16'd0, payload},   {16'd0, mon_ev.payload});
        end
        if (mon_ev.is_cmd) begin
          chk_eq("rnw",  {31'd0, rnw},         {31'd0, mon_ev.rnw});
          chk_eq("code", {25'd0, cmd_code},    {25'd0, mon_ev.code});
          chk_eq("addr", {25'd0, target_addr}, {25'd0, mon_ev.addr});
        end
        if (mon_ev.kind == K_EXIT) chk_eq("busy_at_exit", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b);
    sda = b;
    tick(2);
    scl = ~scl;
    tick(2);
  endtask

  task automatic push_simple(input int kind);
    ev_t ev;
    ev = '0;
    ev.kind = kind[1:0];
    exp_q.push_back(ev);
  endtask

  task automatic do_restart();
    if (scl) begin
      sda = 1'b1;
      tick(2);
      scl = 1'b0;
      tick(2);
    end
    push_simple(K_RESTART);
    m_mode = M_CMD;
    sda = 1'b1; tick(2);
    sda = 1'b0; tick(2);
    sda = 1'b1; tick(2);
    sda = 1'b0; tick(2);
    sda = 1'b1; tick(2);
    scl = 1'b1; tick(2);
  endtask

  task automatic send_word(input logic [1:0] pre, input logic [15:0] w, input logic flip);
    logic [1:0]  pa;
    logic [19:0] bits;
    ev_t         ev;
    pa = par_bits(w);
    ev = '0;
    if (m_mode == M_CMD && pre == 2'b01) begin
      ev.kind = K_WORD; ev.wtype = 2'b00; ev.payload = w; ev.perr = flip;
      ev.is_cmd = 1'b1; ev.rnw = w[15]; ev.code = w[14:8]; ev.addr = w[7:1];
      exp_q.push_back(ev);
      m_crc  = 5'h1F;
      m_mode = (flip || w[15]) ? M_WAIT : M_DATA;
    end else if (m_mode == M_DATA && pre == 2'b10) begin
      ev.kind = K_WORD; ev.wtype = 2'b01; ev.payload = w; ev.perr = flip;
      exp_q.push_back(ev);
      m_crc  = crc5_word(m_crc, w);
      m_mode = flip ? M_WAIT : M_DATA;
    end else if (m_mode != M_WAIT) begin
      push_simple(K_PREERR);
      m_mode = M_WAIT;
    end
    bits = {pre, w, pa[1], pa[0] ^ flip};
    for (int i = 19; i >= 0; i--) bus_bit(bits[i]);
  endtask

  task automatic send_crc(input logic [3:0] token, input logic [4:0] c5);
    logic [10:0] bits;
    ev_t         ev;
    if (m_mode == M_CMD) return;
    if (m_mode == M_DATA) begin
      ev = '0;
      ev.kind = K_WORD; ev.wtype = 2'b10; ev.payload = {7'd0, token, c5};
      ev.cerr = (token != 4'hC) || (c5 != m_crc);
      exp_q.push_back(ev);
      m_mode = M_WAIT;
    end
    bits = {2'b01, token, c5};
    for (int i = 10; i >= 0; i--) bus_bit(bits[i]);
  endtask

  task automatic partial_word();
    logic [1:0] pre;
    pre = (m_mode == M_DATA) ? 2'b10 : 2'b01;
    bus_bit(pre[1]);
    bus_bit(pre[0]);
    for (int i = 0; i < 5; i++) bus_bit(1'($urandom_range(0, 1)));
    if (scl) bus_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic exit_partial();
    partial_word();
    push_simple(K_EXIT);
    m_mode = M_CMD;
    for (int i = 0; i < 4; i++) begin
      sda = 1'b1; tick(2);
      sda = 1'b0; tick(2);
    end
    tick(2);
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  tok;
    logic [4:0]  c5;
    logic [1:0]  pre;
    rst_n = 1'b0; hdr_en = 1'b1; scl = 1'b0; sda = 1'b1;
    tick(3);
    chk_eq("rst_busy",  {31'd0, busy},       32'd0);
    chk_eq("rst_valid", {31'd0, word_valid}, 32'd0);
    chk_eq("rst_code",  {25'd0, cmd_code},   32'd0);
    chk_eq("rst_pay",   {16'd0, payload},    32'd0);
    rst_n = 1'b1;
    tick(2);
    chk_eq("busy_after_rst", {31'd0, busy}, 32'd1);

    // Write command, data, good CRC
    do_restart();
    send_word(2'b01, 16'h0A52, 1'b0);
    send_word(2'b10, 16'h1234, 1'b0);
    send_crc(4'hC, m_crc);
    // Same data, CRC bit 0 flipped; target then sits waiting for a pattern
    do_restart();
    send_word(2'b01, 16'h0A52, 1'b0);
    send_word(2'b10, 16'h1234, 1'b0);
    send_crc(4'hC, m_crc ^ 5'h01);
    tick(4);
    chk_eq("busy_wait_after_crc", {31'd0, busy}, 32'd1);
    // Data with PA0 inverted; following preamble ignored until restart
    do_restart();
    send_word(2'b01, 16'h0A52, 1'b0);
    send_word(2'b10, 16'h5A5A, 1'b1);
    send_word(2'b10, 16'hBEEF, 1'b0);
    do_restart();
    send_word(2'b01, 16'h2C66, 1'b0);
    // Exit pattern mid-payload
    exit_partial();
    // Reset mid-word, then restart and decode
    do_restart();
    send_word(2'b01, 16'h0A52, 1'b0);
    partial_word();
    rst_n = 1'b0;
    tick(2);
    chk_eq("rst_mid_busy", {31'd0, busy},        32'd0);
    chk_eq("rst_mid_code", {25'd0, cmd_code},    32'd0);
    chk_eq("rst_mid_addr", {25'd0, target_addr}, 32'd0);
    chk_eq("rst_mid_q",    exp_q.size(),         32'd0);
    rst_n  = 1'b1;
    m_mode = M_CMD;
    tick(3);
    do_restart();
    send_word(2'b01, 16'h9377, 1'b0);
    // HDR mode dropped mid-word
    do_restart();
    send_word(2'b01, 16'h0A52, 1'b0);
    partial_word();
    hdr_en = 1'b0;
    tick(2);
    chk_eq("hdr_off_busy", {31'd0, busy}, 32'd0);
    hdr_en = 1'b1;
    m_mode = M_CMD;
    tick(2);
    chk_eq("hdr_on_busy", {31'd0, busy}, 32'd1);

    for (int it = 0; it < 40; it++) begin
      do_restart();
      w   = 16'($urandom);
      w[15] = ($urandom_range(0, 5) == 0);
      pre = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'b01;
      send_word(pre, w, $urandom_range(0, 7) == 0);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        case ($urandom_range(0, 9))
          0:       exit_partial();
          1:       send_word(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 16'($urandom), 1'b0);
          default: send_word(2'b10, 16'($urandom), $urandom_range(0, 7) == 0);
        endcase
      end
      tok = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hC;
      c5  = m_crc ^ (($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'h00);
      send_crc(tok, c5);
    end

    tick(20);
    chk_eq("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
